// File: rtl/apb_dual_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_dual_master_arbiter: two requesters sharing one APB master, round-robin |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module apb_dual_master_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [1:0]          req,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic                PREADY,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int              CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [1:0]          ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [1:0]          eff_req;
    logic                sel;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        ack_d      = 2'b00;
        rdata_d    = '0;
        err_d      = 1'b0;
        // A port being acked this cycle still shows its old req; ignore it.
        eff_req    = req & ~ack_q;
        sel        = (eff_req == 2'b11) ? ~last_gnt_q : eff_req[1];

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (eff_req != 2'b00) begin
                    gnt_d      = sel;
                    last_gnt_d = sel;
                    pwrite_d   = sel ? req_write[1] : req_write[0];
                    paddr_d    = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    pwdata_d   = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    psel_d     = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ack_d     = gnt_q ? 2'b10 : 2'b01;
                    err_d     = PSLVERR;
                    rdata_d   = pwrite_q ? '0 : PRDATA;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TIMEOUT != 0 && cnt_d == TO_LIM) begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        ack_d     = gnt_q ? 2'b10 : 2'b01;
                        err_d     = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            cnt_q      <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            ack_q      <= 2'b00;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign ack       = ack_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_dual_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_dual_master_arbiter: scoreboard bench with a wait-state APB slave    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_apb_dual_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  ack;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [8:0]  PADDR;
    logic [7:0]  PWDATA;
    logic        PREADY;
    logic [7:0]  PRDATA;
    logic        PSLVERR;

    apb_dual_master_arbiter #(.ADDR_W(9), .DATA_W(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [8:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
        int         acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   ord_q[$];
    int   checks = 0;
    int   errors = 0;

    // slave model controls and observations
    int         ws = 0;
    bit         hang = 0;
    bit         serr = 0;
    int         acc = 0;
    int         last_acc = 0;
    logic [8:0] cap_addr;
    logic       cap_wr;
    logic [7:0] cap_wdata;
    logic       prev_psel = 0, prev_pen = 0;
    logic [8:0] prev_addr = '0;
    int         b2b_left = 0;
    bit         b2b_expect = 0;

    function automatic void chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor + slave: samples 1 time unit after each rising edge
    always @(posedge PCLK) begin
        exp_t e;
        int   p;
        int   o;
        #1;
        if (b2b_expect) begin
            b2b_expect = 0;
            chk(PSEL === 1'b1 && PENABLE === 1'b0, "b2b_setup", {30'd0, PSEL, PENABLE}, 32'h2);
        end
        if (ack !== 2'b00) begin
            chk(ack === 2'b01 || ack === 2'b10, "ack_onehot", {30'd0, ack}, 32'h1);
            p = ack[1] ? 1 : 0;
            if (ord_q.size() == 0) begin
                chk(0, "unexpected_order", p, 32'hFFFF);
            end else begin
                o = ord_q.pop_front();
                chk(p == o, "grant_order", p, o);
            end
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                chk(0, "unexpected_ack", {30'd0, ack}, 32'h0);
            end else begin
                e = (p == 0) ? q0.pop_front() : q1.pop_front();
                chk(rsp_rdata === e.rdata, "rsp_rdata", rsp_rdata, e.rdata);
                chk(rsp_err === e.err, "rsp_err", rsp_err, e.err);
                chk(cap_addr === e.addr, "paddr", cap_addr, e.addr);
                chk(cap_wr === e.wr, "pwrite", cap_wr, e.wr);
                if (e.wr) chk(cap_wdata === e.wdata, "pwdata", cap_wdata, e.wdata);
                if (e.acc > 0) chk(last_acc == e.acc, "access_cycles", last_acc, e.acc);
            end
            if (b2b_left > 0) begin
                b2b_left--;
                b2b_expect = 1;
            end
        end else begin
            chk(rsp_rdata === 8'h00 && rsp_err === 1'b0, "rsp_idle", {23'd0, rsp_err, rsp_rdata}, 32'h0);
        end
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            acc++;
            if (acc == 1)
                chk(prev_psel && !prev_pen && prev_addr == PADDR, "setup_before_access",
                    {30'd0, prev_psel, prev_pen}, 32'h2);
            cap_addr  = PADDR;
            cap_wr    = PWRITE;
            cap_wdata = PWDATA;
            last_acc  = acc;
            PREADY    = !hang && (acc > ws);
            PRDATA    = serr ? 8'h00 : PADDR[7:0];
            PSLVERR   = serr;
        end else begin
            acc     = 0;
            PREADY  = 1'b0;
            PRDATA  = 8'h00;
            PSLVERR = 1'b0;
        end
        prev_psel = PSEL;
        prev_pen  = PENABLE;
        prev_addr = PADDR;
    end

    task automatic xfer(input int p, input bit w, input logic [8:0] a, input logic [7:0] d,
                        input bit to_exp, input int exp_acc);
        exp_t e;
        bit   got = 0;
        e.addr  = a;
        e.wr    = w;
        e.wdata = d;
        e.err   = to_exp || serr;
        e.rdata = (w || e.err) ? 8'h00 : a[7:0];
        e.acc   = exp_acc;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
        req_write[p] = w;
        if (p == 0) begin
            req_addr[8:0]  = a;
            req_wdata[7:0] = d;
        end else begin
            req_addr[17:9]  = a;
            req_wdata[15:8] = d;
        end
        req[p] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge PCLK);
            #2;
            if (ack[p] === 1'b1) begin
                got = 1;
                break;
            end
        end
        req[p] = 1'b0;
        chk(got, "ack_wait", {31'd0, got}, 32'h1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual running required finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bit in_access;
        PRESETn   = 1'b1;
        req       = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = 8'h00;
        PSLVERR   = 1'b0;
        #3 PRESETn = 1'b0;
        #1;
        chk({PSEL, PENABLE, PWRITE, PADDR, PWDATA, ack, rsp_rdata, rsp_err} === '0, "reset_state",
            {PSEL, PENABLE, PWRITE, PADDR, PWDATA, ack}, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        // 1: single write, zero wait states
        ord_q.push_back(0);
        xfer(0, 1'b1, 9'h005, 8'h0A, 1'b0, 1);

        // 2: read with three wait states
        ws = 3;
        ord_q.push_back(1);
        xfer(1, 1'b0, 9'h103, 8'h00, 1'b0, 4);
        ws = 0;

        // 3: both ports streaming, alternating grants, no gap
        repeat (2) @(posedge PCLK);
        #2;
        b2b_left = 3;
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
        fork
            begin
                xfer(0, 1'b1, 9'h010, 8'h11, 1'b0, 1);
                xfer(0, 1'b0, 9'h012, 8'h00, 1'b0, 1);
            end
            begin
                xfer(1, 1'b0, 9'h120, 8'h00, 1'b0, 1);
                xfer(1, 1'b1, 9'h121, 8'h22, 1'b0, 1);
            end
        join
        b2b_left = 0;

        // 4: slave error on a read
        serr = 1;
        ord_q.push_back(0);
        xfer(0, 1'b0, 9'h02D, 8'h00, 1'b0, 1);
        serr = 0;

        // 5: slave never ready, then normal traffic
        hang = 1;
        ord_q.push_back(1);
        xfer(1, 1'b0, 9'h144, 8'h00, 1'b1, 16);
        hang = 0;
        ord_q.push_back(0);
        xfer(0, 1'b0, 9'h0AA, 8'h00, 1'b0, 1);

        // 6: reset during ACCESS, then simultaneous requests
        hang = 1;
        req_write[0]  = 1'b1;
        req_addr[8:0] = 9'h011;
        req[0]        = 1'b1;
        in_access     = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge PCLK);
            #2;
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                in_access = 1;
                break;
            end
        end
        chk(in_access, "reach_access", {31'd0, in_access}, 32'h1);
        req[0] = 1'b0;
        #1 PRESETn = 1'b0;
        #1;
        chk(PSEL === 1'b0, "reset_psel", {31'd0, PSEL}, 32'h0);
        chk(PENABLE === 1'b0, "reset_penable", {31'd0, PENABLE}, 32'h0);
        chk(ack === 2'b00, "reset_ack", {30'd0, ack}, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        hang    = 0;
        repeat (3) @(negedge PCLK);
        ord_q.push_back(0); ord_q.push_back(1);
        fork
            xfer(0, 1'b1, 9'h033, 8'h5C, 1'b0, 1);
            xfer(1, 1'b0, 9'h1F0, 8'h00, 1'b0, 1);
        join

        repeat (4) @(posedge PCLK);
        #3;
        chk(q0.size() == 0 && q1.size() == 0, "scoreboard_drained", q0.size() + q1.size(), 32'h0);
        chk(ord_q.size() == 0, "order_drained", ord_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
